// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto a single shared memory port, one transaction outstanding.
// Accept in IDLE (same-cycle ready), issue next cycle; stalls in REQ/RESP hold all state.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [AW-1:0]     m0_addr,
    input  logic              m0_wen,
    input  logic [DW-1:0]     m0_wdata,
    input  logic [DW/8-1:0]   m0_wmask,
    output logic              m0_resp_valid,
    input  logic              m0_resp_ready,
    output logic [DW-1:0]     m0_rdata,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [AW-1:0]     m1_addr,
    input  logic              m1_wen,
    input  logic [DW-1:0]     m1_wdata,
    input  logic [DW/8-1:0]   m1_wmask,
    output logic              m1_resp_valid,
    input  logic              m1_resp_ready,
    output logic [DW-1:0]     m1_rdata,

    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [AW-1:0]     s_addr,
    output logic              s_wen,
    output logic [DW-1:0]     s_wdata,
    output logic [DW/8-1:0]   s_wmask,
    input  logic              s_resp_valid,
    output logic              s_resp_ready,
    input  logic [DW-1:0]     s_rdata,

    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;     // 1 = m1 owned the previous transaction
    logic   pick_m1;
    logic   in_idle;
    logic   in_resp;
    logic   accept;
    logic   owner_resp_ready;

    // m1 wins when it is the only requester, or on a tie when m0 went last.
    always_comb begin
        pick_m1 = m1_req_valid & (~m0_req_valid | ~last_grant);
    end

    assign in_idle = rst & (state == IDLE);
    assign in_resp = rst & (state == RESP);

    assign m0_req_ready = in_idle & m0_req_valid & ~pick_m1;
    assign m1_req_ready = in_idle & pick_m1;
    assign accept       = m0_req_ready | m1_req_ready;

    assign owner_resp_ready = grant[1] ? m1_resp_ready : m0_resp_ready;

    assign s_req_valid   = rst & (state == REQ);
    assign s_resp_ready  = in_resp & owner_resp_ready;
    assign m0_resp_valid = in_resp & grant[0] & s_resp_valid;
    assign m1_resp_valid = in_resp & grant[1] & s_resp_valid;

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            s_addr     <= '0;
            s_wen      <= 1'b0;
            s_wdata    <= '0;
            s_wmask    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (pick_m1) begin
                            s_addr  <= m1_addr;
                            s_wen   <= m1_wen;
                            s_wdata <= m1_wdata;
                            s_wmask <= m1_wmask;
                            grant   <= 2'b10;
                        end else begin
                            s_addr  <= m0_addr;
                            s_wen   <= m0_wen;
                            s_wdata <= m0_wdata;
                            s_wmask <= m0_wmask;
                            grant   <= 2'b01;
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (s_req_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (s_resp_valid && owner_resp_ready) begin
                        last_grant <= grant[1];
                        grant      <= 2'b00;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, per-cycle compare, directed scenarios then random traffic.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_resp_ready;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [MW-1:0] m0_wmask;
    logic          m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [MW-1:0] m1_wmask;
    logic          s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [MW-1:0] s_wmask;
    logic [1:0]    grant;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_rdata(m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_rdata(m1_rdata),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_rdata(s_rdata),
        .grant(grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction record plus round-robin memory.
    bit            started = 0;
    bit            busy = 0;
    bit            issued = 0;
    int            owner = 0;
    int            last = 1;
    logic [AW-1:0] h_addr = '0;
    logic          h_wen = 1'b0;
    logic [DW-1:0] h_wdata = '0;
    logic [MW-1:0] h_wmask = '0;
    int            waitc[2] = '{0, 0};
    bit            acc[2] = '{0, 0};
    int            glog[$];

    function automatic bit vld(input int i);
        return (i == 0) ? m0_req_valid : m1_req_valid;
    endfunction

    function automatic int winner();
        if (!rst || busy) return -1;
        if (m0_req_valid && m1_req_valid) return (last == 0) ? 1 : 0;
        if (m0_req_valid) return 0;
        if (m1_req_valid) return 1;
        return -1;
    endfunction

    function automatic bit owner_rr();
        return (owner == 0) ? m0_resp_ready : m1_resp_ready;
    endfunction

    always @(posedge clk) begin : model
        int w;
        w = winner();
        acc[0] = 0;
        acc[1] = 0;
        started = 1;
        if (!rst) begin
            busy = 0; issued = 0; last = 1;
            h_addr = '0; h_wen = 1'b0; h_wdata = '0; h_wmask = '0;
            waitc[0] = 0; waitc[1] = 0;
        end else if (!busy) begin
            if (w >= 0) begin
                checks++;
                if (waitc[w] > 1) begin
                    errors++;
                    $display("FAIL fairness m%0d waited %0d grants, allowed 1", w, waitc[w]);
                end
                waitc[w] = 0;
                if (vld(1 - w)) waitc[1 - w]++;
                acc[w] = 1;
                busy = 1; issued = 0; owner = w;
                h_addr  = (w == 0) ? m0_addr  : m1_addr;
                h_wen   = (w == 0) ? m0_wen   : m1_wen;
                h_wdata = (w == 0) ? m0_wdata : m1_wdata;
                h_wmask = (w == 0) ? m0_wmask : m1_wmask;
            end
        end else if (!issued) begin
            if (s_req_ready) issued = 1;
        end else if (s_resp_valid && owner_rr()) begin
            busy = 0;
            last = owner;
        end
        for (int i = 0; i < 2; i++) if (!vld(i)) waitc[i] = 0;
    end

    always @(negedge clk) begin : compare
        int w;
        bit rr;
        if (started) begin
            w  = winner();
            rr = rst && busy && issued;
            chk("m0_req_ready", m0_req_ready, w == 0);
            chk("m1_req_ready", m1_req_ready, w == 1);
            chk("s_req_valid", s_req_valid, rst && busy && !issued);
            chk("s_resp_ready", s_resp_ready, rr && owner_rr());
            chk("m0_resp_valid", m0_resp_valid, rr && owner == 0 && s_resp_valid);
            chk("m1_resp_valid", m1_resp_valid, rr && owner == 1 && s_resp_valid);
            chk("grant", grant, busy ? ((owner == 0) ? 2'b01 : 2'b10) : 2'b00);
            chk("s_addr", s_addr, h_addr);
            chk("s_wen", s_wen, h_wen);
            chk("s_wdata", s_wdata, h_wdata);
            chk("s_wmask", s_wmask, h_wmask);
            chk("m0_rdata", m0_rdata, s_rdata);
            chk("m1_rdata", m1_rdata, s_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        m0_req_valid = 1'b1; m0_addr = '0; m0_wen = 1'b0; m0_wdata = '0; m0_wmask = '0; m0_resp_ready = 1'b0;
        m1_req_valid = 1'b0; m1_addr = '0; m1_wen = 1'b0; m1_wdata = '0; m1_wmask = '0; m1_resp_ready = 1'b0;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;

        // Reset: ready/valid held low even with a requester present
        at_neg();
        chk("rst m0_req_ready", m0_req_ready, 1'b0);
        tick(); tick();
        at_neg();
        chk("rst grant", grant, 2'b00);
        chk("rst s_req_valid", s_req_valid, 1'b0);
        chk("rst s_addr", s_addr, 32'h0);
        m0_req_valid = 1'b0;

        // Single read from m0
        tick();
        rst = 1'b1;
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0000; m0_wen = 1'b0;
        s_req_ready = 1'b1; m0_resp_ready = 1'b1;
        at_neg();
        chk("rd accept", m0_req_ready, 1'b1);
        tick();
        m0_req_valid = 1'b0; m0_addr = 32'h0;
        at_neg();
        chk("rd s_req_valid", s_req_valid, 1'b1);
        chk("rd s_addr", s_addr, 32'h8000_0000);
        chk("rd grant", grant, 2'b01);
        tick();
        s_resp_valid = 1'b1; s_rdata = 32'h0000_0413; s_req_ready = 1'b0;
        at_neg();
        chk("rd resp_valid", m0_resp_valid, 1'b1);
        chk("rd rdata", m0_rdata, 32'h0000_0413);
        chk("rd resp grant", grant, 2'b01);
        tick();
        s_resp_valid = 1'b0;
        at_neg();
        chk("rd idle grant", grant, 2'b00);

        // Round-robin from reset with both masters always requesting
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        s_req_ready = 1'b1; s_resp_valid = 1'b1; m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
        glog.delete();
        for (int i = 0; i < 12; i++) begin
            at_neg();
            if (m0_req_ready) glog.push_back(0);
            if (m1_req_ready) glog.push_back(1);
            tick();
        end
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_resp_valid = 1'b0;
        chk("rr count", glog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("rr order", (i < glog.size()) ? glog[i] : -1, i % 2);

        // m1 write with memory stalling the request for three cycles
        m1_req_valid = 1'b1; m1_addr = 32'h8000_0010; m1_wen = 1'b1;
        m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'hF; s_req_ready = 1'b0;
        at_neg();
        chk("wr accept", m1_req_ready, 1'b1);
        tick();
        m1_req_valid = 1'b0; m1_addr = 32'h1234_5678; m1_wen = 1'b0; m1_wdata = '0; m1_wmask = '0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) s_req_ready = 1'b1;
            if (k == 1) m1_addr = 32'hFFFF_0000;
            at_neg();
            chk("wr s_req_valid", s_req_valid, 1'b1);
            chk("wr s_addr", s_addr, 32'h8000_0010);
            chk("wr s_wdata", s_wdata, 32'hDEAD_BEEF);
            chk("wr s_wen", s_wen, 1'b1);
            chk("wr s_wmask", s_wmask, 4'hF);
            tick();
        end
        s_req_ready = 1'b0; s_resp_valid = 1'b1; m1_resp_ready = 1'b1;
        at_neg();
        chk("wr resp_valid", m1_resp_valid, 1'b1);
        tick();
        s_resp_valid = 1'b0;

        // Response back-pressure from m0 while m1 waits
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0020; m0_wen = 1'b0;
        s_req_ready = 1'b1; m0_resp_ready = 1'b0;
        at_neg();
        chk("bp accept", m0_req_ready, 1'b1);
        tick();
        m0_req_valid = 1'b0; m1_req_valid = 1'b1; m1_addr = 32'h8000_0040;
        tick();
        s_req_ready = 1'b0; s_resp_valid = 1'b1;
        repeat (5) begin
            at_neg();
            chk("bp m0_resp_valid", m0_resp_valid, 1'b1);
            chk("bp s_resp_ready", s_resp_ready, 1'b0);
            chk("bp m1_req_ready", m1_req_ready, 1'b0);
            chk("bp grant", grant, 2'b01);
            tick();
        end
        m0_resp_ready = 1'b1;
        at_neg();
        chk("bp s_resp_ready", s_resp_ready, 1'b1);
        tick();
        at_neg();
        chk("bp m1 accept", m1_req_ready, 1'b1);
        tick();
        m1_req_valid = 1'b0; s_req_ready = 1'b1; m1_resp_ready = 1'b1;
        tick(); tick();
        s_resp_valid = 1'b0; s_req_ready = 1'b0;

        // Reset while in REQ abandons the transaction
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0030;
        at_neg();
        chk("mr accept", m0_req_ready, 1'b1);
        tick();
        m0_req_valid = 1'b0;
        at_neg();
        chk("mr s_req_valid", s_req_valid, 1'b1);
        tick();
        rst = 1'b0; s_resp_valid = 1'b1; s_req_ready = 1'b1; m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        tick();
        at_neg();
        chk("mr s_req_valid low", s_req_valid, 1'b0);
        chk("mr grant", grant, 2'b00);
        chk("mr m0_resp_valid", m0_resp_valid, 1'b0);
        chk("mr m0_req_ready", m0_req_ready, 1'b0);
        tick();
        rst = 1'b1;
        at_neg();
        chk("mr tie m0", m0_req_ready, 1'b1);
        chk("mr tie m1", m1_req_ready, 1'b0);
        tick();
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        s_resp_valid = 1'b0; s_req_ready = 1'b0;

        // Random traffic; requests stay up (with stable fields) until accepted
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst = ($urandom_range(0, 399) != 0);
            if (!m0_req_valid || acc[0]) begin
                m0_req_valid = ($urandom_range(0, 2) != 0);
                m0_addr = $urandom; m0_wen = $urandom_range(0, 1);
                m0_wdata = $urandom; m0_wmask = $urandom_range(0, 15);
            end
            if (!m1_req_valid || acc[1]) begin
                m1_req_valid = ($urandom_range(0, 2) != 0);
                m1_addr = $urandom; m1_wen = $urandom_range(0, 1);
                m1_wdata = $urandom; m1_wmask = $urandom_range(0, 15);
            end
            m0_resp_ready = ($urandom_range(0, 3) != 0);
            m1_resp_ready = ($urandom_range(0, 3) != 0);
            s_req_ready   = $urandom_range(0, 1);
            s_resp_valid  = $urandom_range(0, 1);
            s_rdata       = $urandom;
        end
        tick();
        rst = 1'b1; m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        s_req_ready = 1'b1; s_resp_valid = 1'b1; m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
        repeat (8) tick();
        at_neg();
        chk("drain grant", grant, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; mask width is DW/8.
REQ-003 Ports are listed in REQ-004 to REQ-024 as name, direction, width, meaning; `m{0,1}` denotes one identical port per master.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 m{0,1}_req_valid  in  1  master request present; m0 = instruction fetch, m1 = load/store.
REQ-007 m{0,1}_req_ready  out  1  request accepted this cycle.
REQ-008 m{0,1}_addr  in  AW  request address.
REQ-009 m{0,1}_wen  in  1  1 = write, 0 = read.
REQ-010 m{0,1}_wdata  in  DW  write data.
REQ-011 m{0,1}_wmask  in  DW/8  byte write mask.
REQ-012 m{0,1}_resp_valid  out  1  response present for that master.
REQ-013 m{0,1}_resp_ready  in  1  master accepts response.
REQ-014 m{0,1}_rdata  out  DW  response data (s_rdata broadcast).
REQ-015 s_req_valid  out  1  request to shared memory.
REQ-016 s_req_ready  in  1  memory accepts request.
REQ-017 s_addr  out  AW  held address.
REQ-018 s_wen  out  1  held write enable.
REQ-019 s_wdata  out  DW  held write data.
REQ-020 s_wmask  out  DW/8  held mask.
REQ-021 s_resp_valid  in  1  memory response, issued for reads and writes.
REQ-022 s_resp_ready  out  1  arbiter accepts response.
REQ-023 s_rdata  in  DW  memory read data.
REQ-024 grant  out  2  one-hot owner ({m1,m0}); 2'b00 when idle.

Function
REQ-025 FSM states: IDLE, REQ, RESP; at most one transaction outstanding.
REQ-026 IDLE, one requester valid: that master wins.
REQ-027 IDLE, both requesters valid: round-robin; the master not in last_grant wins.
REQ-028 In IDLE, mX_req_ready for the winner is asserted combinationally in the same cycle as its req_valid.
REQ-029 On that handshake: capture addr/wen/wdata/wmask into holding registers, set grant, go to REQ.
REQ-030 REQ: s_req_valid=1 with held fields, stable until s_req_ready=1; then go to RESP.
REQ-031 RESP: s_resp_ready = granted master's resp_ready, and granted mX_resp_valid = s_resp_valid.
REQ-032 RESP: on the s_resp_valid & s_resp_ready handshake, last_grant := owner and go to IDLE.
REQ-033 Non-owner: req_ready=0 and resp_valid=0 at all times; its requests wait and are never dropped.
REQ-034 s_req_valid=0 outside REQ; s_resp_ready=0 outside RESP; grant=2'b00 only in IDLE.
REQ-035 Latency: accept at cycle N; s_req_valid at N+1; with s_req_ready=1 and s_resp_valid=1 immediately, response to the master at N+2; next accept no earlier than N+3.
REQ-036 Requester changes fields after acceptance: no effect; held copies are used.
REQ-037 Back-pressure: resp_ready=0 stalls in RESP indefinitely; s_resp_ready stays 0.
REQ-038 No timeout; memory stall holds the REQ/RESP state.
REQ-039 The fairness bound is one transaction: a continuously requesting master is granted within one other grant.

Reset
REQ-040 While rst=0 at a clock edge: state=IDLE, grant=2'b00, last_grant=m1 (so m0 wins the first tie), holding registers=0.
REQ-041 While rst=0: all ready/valid outputs are 0.
REQ-042 Reset mid-transaction abandons it; no response is delivered to either master afterwards.

Verification
REQ-043 m0 reads 0x8000_0000; memory returns 0x0000_0413 next cycle -> m0_resp_valid=1, m0_rdata=0x0000_0413, grant=01, back to IDLE.
REQ-044 m0 and m1 both valid from reset -> grant order m0, m1, m0, m1 over 4 transactions.
REQ-045 m1 writes 0x8000_0010 with wdata 0xDEADBEEF, wmask 0xF; s_req_ready held 0 for 3 cycles -> s_req_valid/s_addr/s_wdata stable for all 4 cycles; m1 changing its inputs meanwhile has no effect.
REQ-046 m0_resp_ready=0 for 5 cycles while s_resp_valid=1 -> stays in RESP, s_resp_ready=0, m1 not granted until the handshake.
REQ-047 rst=0 asserted in REQ -> next cycle all outputs 0 and grant=00; after release, m0 wins the first tie.
